// File: rtl/chain_code_loader.sv
// chain_code_loader: receives one chain-code frame as a byte stream (5-byte header plus codes),
// validates it, buffers the 3-bit codes in a register array, then launches the decoder
// with a start pulse, held header outputs and one code per valid/ready handshake.
module chain_code_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        start,
    output logic [6:0]  start_pixel_x,
    output logic [6:0]  start_pixel_y,
    output logic [7:0]  perimeter,
    output logic [11:0] area,
    output logic [7:0]  code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        stream_done,
    output logic        busy,
    output logic        frame_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // Pointers must reach DEPTH itself and be comparable with the 8-bit perimeter.
    localparam int unsigned CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

    typedef enum logic [2:0] {
        StHdr,
        StCodes,
        StLaunch,
        StStream,
        StError
    } state_t;

    state_t        state;
    logic [2:0]    hdr_cnt;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] perim_ext;
    logic          accept;
    logic [2:0]    mem [DEPTH];

    assign perim_ext   = CW'(perimeter);
    // Gated by reset so every output reads 0 while reset is held.
    assign in_ready    = ~reset & ((state == StHdr) | (state == StCodes));
    assign accept      = in_valid & in_ready;
    assign start       = (state == StLaunch);
    assign frame_error = (state == StError);
    assign code_valid  = (state == StStream) && (rd_ptr < perim_ext);
    assign stream_done = (state == StStream) && (rd_ptr == perim_ext);
    // Masked so uninitialised buffer contents never reach the port.
    assign code        = code_valid ? {5'b0, mem[rd_ptr[ADDR_W-1:0]]} : 8'h00;
    assign busy        = ((state == StHdr) && (hdr_cnt != 3'd0)) || (state == StCodes)
                         || (state == StLaunch) || ((state == StStream) && !stream_done);

    // Frame sequencing, header capture and pointer management.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StHdr;
            hdr_cnt       <= 3'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            start_pixel_x <= 7'd0;
            start_pixel_y <= 7'd0;
            perimeter     <= 8'd0;
            area          <= 12'd0;
        end else begin
            case (state)
                StHdr: begin
                    if (accept) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            3'd0: begin
                                start_pixel_x <= in_data[6:0];
                                if (in_data[7]) state <= StError;
                            end
                            3'd1: begin
                                start_pixel_y <= in_data[6:0];
                                if (in_data[7]) state <= StError;
                            end
                            3'd2: begin
                                perimeter <= in_data;
                                if (32'(in_data) > DEPTH) state <= StError;
                            end
                            3'd3: begin
                                area[11:8] <= in_data[3:0];
                                if (in_data[7:4] != 4'd0) state <= StError;
                            end
                            default: begin
                                area[7:0] <= in_data;
                                hdr_cnt   <= 3'd0;
                                state     <= (perimeter == 8'd0) ? StLaunch : StCodes;
                            end
                        endcase
                    end
                end
                StCodes: begin
                    if (accept) begin
                        if (in_data[7:3] != 5'd0) begin
                            state <= StError;
                        end else begin
                            wr_ptr <= wr_ptr + CW'(1);
                            if (wr_ptr + CW'(1) == perim_ext) state <= StLaunch;
                        end
                    end
                end
                StLaunch: begin
                    rd_ptr <= '0;
                    state  <= StStream;
                end
                StStream: begin
                    if (rd_ptr == perim_ext) begin
                        state   <= StHdr;
                        hdr_cnt <= 3'd0;
                        wr_ptr  <= '0;
                    end else if (code_ready) begin
                        rd_ptr <= rd_ptr + CW'(1);
                    end
                end
                StError: begin
                    state <= StError;
                end
                default: begin
                    state <= StHdr;
                end
            endcase
        end
    end

    // Code buffer write; rejected bytes never land in the array.
    always_ff @(posedge clk) begin
        if ((state == StCodes) && accept && (in_data[7:3] == 5'd0)) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data[2:0];
        end
    end

endmodule

// File: tb/tb_chain_code_loader.sv
// tb_chain_code_loader: scoreboard bench; code bytes push expected codes when sent,
// handshakes on the code port pop and compare them.
module tb_chain_code_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        start;
    logic [6:0]  start_pixel_x;
    logic [6:0]  start_pixel_y;
    logic [7:0]  perimeter;
    logic [11:0] area;
    logic [7:0]  code;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic        stream_done;
    logic        busy;
    logic        frame_error;

    logic        in_valid2 = 1'b0;
    logic [7:0]  in_data2 = 8'h00;
    logic        in_ready2;
    logic        start2;
    logic [6:0]  start_pixel_x2;
    logic [6:0]  start_pixel_y2;
    logic [7:0]  perimeter2;
    logic [11:0] area2;
    logic [7:0]  code2;
    logic        code_valid2;
    logic        stream_done2;
    logic        busy2;
    logic        frame_error2;

    int tests_run = 0;
    int tests_failed = 0;
    int start_cnt = 0;
    int cv_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    chain_code_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .start_pixel_x(start_pixel_x), .start_pixel_y(start_pixel_y),
        .perimeter(perimeter), .area(area), .code(code), .code_valid(code_valid),
        .code_ready(code_ready), .stream_done(stream_done), .busy(busy),
        .frame_error(frame_error)
    );

    chain_code_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .start(start2), .start_pixel_x(start_pixel_x2),
        .start_pixel_y(start_pixel_y2), .perimeter(perimeter2), .area(area2), .code(code2),
        .code_valid(code_valid2), .code_ready(1'b0), .stream_done(stream_done2),
        .busy(busy2), .frame_error(frame_error2)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (code_valid) cv_cnt++;
    end

    task automatic apply_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        code_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        if (sel) begin
            in_valid2 = 1'b1;
            in_data2 = b;
        end else begin
            in_valid = 1'b1;
            in_data = b;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? in_ready2 : in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL send_byte: byte %02h not accepted, in_ready=0 required 1", b);
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i >= 5) exp_q.push_back({5'b0, frame_q[i][2:0]});
            send_byte(1'b0, frame_q[i]);
            if (i >= 5 && i < frame_q.size() - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        frame_q.delete();
    endtask

    task automatic drain(input int stall_idx, input int stall_len, input bit check_tput);
        int got;
        int stall;
        int first_hs;
        int last_hs;
        bit done;
        logic [7:0] e;
        got = 0; stall = 0; first_hs = -1; last_hs = -1; done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            code_ready = !(got == stall_idx && stall < stall_len);
            @(negedge clk);
            if (stream_done) begin
                done = 1'b1;
                tests_run++;
                if (exp_q.size() != 0 || code_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stream_done: %0d codes left, code_valid=%b, required 0 and 0",
                             exp_q.size(), code_valid);
                end
                if (last_hs >= 0) begin
                    tests_run++;
                    if (cyc - last_hs != 1) begin
                        tests_failed++;
                        $display("FAIL done_latency: %0d cycles after last handshake, required 1",
                                 cyc - last_hs);
                    end
                end
                if (check_tput && first_hs >= 0) begin
                    tests_run++;
                    if (last_hs - first_hs != got - 1) begin
                        tests_failed++;
                        $display("FAIL throughput: %0d codes over %0d cycles, required %0d",
                                 got, last_hs - first_hs + 1, got);
                    end
                end
            end else if (code_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extra_code: code=%02h valid, required no code", code);
                end else if (!code_ready) begin
                    stall++;
                    if (code !== exp_q[0] || dut.rd_ptr !== 9'(got)) begin
                        tests_failed++;
                        $display("FAIL stall_hold: code=%02h rd_ptr=%0d, required %02h and %0d",
                                 code, dut.rd_ptr, exp_q[0], got);
                    end
                end else begin
                    e = exp_q.pop_front();
                    if (code !== e) begin
                        tests_failed++;
                        $display("FAIL code_%0d: got %02h, required %02h", got, code, e);
                    end
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    got++;
                end
            end
            @(posedge clk);
            #1;
        end
        code_ready = 1'b0;
        if (stall_idx >= 0) begin
            tests_run++;
            if (stall != stall_len) begin
                tests_failed++;
                $display("FAIL stall_len: code_valid held %0d stalled cycles, required %0d",
                         stall, stall_len);
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL drain_timeout: stream_done=0 after 300 cycles, required 1");
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [47:0] all;
        all = {in_ready, start, start_pixel_x, start_pixel_y, perimeter, area, code, code_valid,
               stream_done, busy, frame_error};
        tests_run++;
        if (all !== 48'h0 || in_ready2 !== 1'b0 || frame_error2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: outputs=%012h in_ready2=%b, required all 0", name, all, in_ready2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || frame_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b busy=%b frame_error=%b, required 1 0 0",
                     in_ready, busy, frame_error);
        end
    endtask

    task automatic load_basic_frame();
        frame_q = '{8'h0A, 8'h14, 8'h03, 8'h00, 8'h12, 8'h00, 8'h02, 8'h06};
        send_frame(0);
    endtask

    task automatic test_frame();
        int s0;
        s0 = start_cnt;
        load_basic_frame();
        tests_run++;
        if (start !== 1'b1 || code_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL launch: start=%b code_valid=%b busy=%b, required 1 0 1",
                     start, code_valid, busy);
        end
        tests_run++;
        if (start_pixel_x !== 7'd10 || start_pixel_y !== 7'd20 || perimeter !== 8'd3
            || area !== 12'h012) begin
            tests_failed++;
            $display("FAIL header: x=%0d y=%0d p=%0d area=%03h, required 10 20 3 012",
                     start_pixel_x, start_pixel_y, perimeter, area);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (start !== 1'b0 || code_valid !== 1'b1 || code !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_code: start=%b code_valid=%b code=%02h, required 0 1 00",
                     start, code_valid, code);
        end
        drain(-1, 0, 1'b1);
        tests_run++;
        if (start_cnt != s0 + 1 || perimeter !== 8'd3 || busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_end: starts=%0d p=%0d busy=%b in_ready=%b, required 1 3 0 1",
                     start_cnt - s0, perimeter, busy, in_ready);
        end
    endtask

    task automatic test_backpressure();
        load_basic_frame();
        @(posedge clk);
        #1;
        drain(1, 4, 1'b0);
    endtask

    task automatic test_zero_perimeter();
        int c0;
        c0 = cv_cnt;
        frame_q = '{8'h05, 8'h05, 8'h00, 8'h00, 8'h01};
        send_frame(0);
        tests_run++;
        if (start !== 1'b1 || stream_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_launch: start=%b stream_done=%b, required 1 0", start, stream_done);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (stream_done !== 1'b1 || code_valid !== 1'b0 || busy !== 1'b0 || start !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done: done=%b code_valid=%b busy=%b start=%b, required 1 0 0 0",
                     stream_done, code_valid, busy, start);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || stream_done !== 1'b0 || cv_cnt != c0) begin
            tests_failed++;
            $display("FAIL zero_after: in_ready=%b done=%b code_valid cycles=%0d, required 1 0 0",
                     in_ready, stream_done, cv_cnt - c0);
        end
    endtask

    task automatic test_code_error();
        int s0;
        apply_reset();
        s0 = start_cnt;
        frame_q = '{8'h0A, 8'h14, 8'h03, 8'h00, 8'h12, 8'h00, 8'h02, 8'h09};
        send_frame(0);
        tests_run++;
        if (frame_error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL code_error: frame_error=%b in_ready=%b busy=%b, required 1 0 0",
                     frame_error, in_ready, busy);
        end
        in_valid = 1'b1;
        in_data = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (frame_error !== 1'b1 || in_ready !== 1'b0 || start_cnt != s0 || code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_hold: frame_error=%b in_ready=%b starts=%0d cv=%b, required 1 0 0 0",
                     frame_error, in_ready, start_cnt - s0, code_valid);
        end
        apply_reset();
        tests_run++;
        if (frame_error !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL error_clear: frame_error=%b in_ready=%b, required 0 1",
                     frame_error, in_ready);
        end
        test_frame();
    endtask

    task automatic test_header_error();
        apply_reset();
        send_byte(1'b0, 8'h80);
        tests_run++;
        if (frame_error !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL byte0_error: frame_error=%b in_ready=%b, required 1 0",
                     frame_error, in_ready);
        end
        apply_reset();
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h04);
        tests_run++;
        if (frame_error2 !== 1'b0 || busy2 !== 1'b1 || perimeter2 !== 8'd4) begin
            tests_failed++;
            $display("FAIL depth_equal: frame_error=%b busy=%b p=%0d, required 0 1 4",
                     frame_error2, busy2, perimeter2);
        end
        apply_reset();
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h00);
        tests_run++;
        if (frame_error2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL depth_early: frame_error=%b, required 0", frame_error2);
        end
        send_byte(1'b1, 8'h05);
        tests_run++;
        if (frame_error2 !== 1'b1 || in_ready2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL depth_over: frame_error=%b in_ready=%b, required 1 0",
                     frame_error2, in_ready2);
        end
        apply_reset();
    endtask

    task automatic test_async_reset();
        frame_q = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h20, 8'h01, 8'h03, 8'h05, 8'h07};
        send_frame(0);
        code_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        #2 reset = 1'b0;
        code_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        test_frame();
    endtask

    task automatic test_back_to_back();
        frame_q = '{8'h7F, 8'h00, 8'h05, 8'h0F, 8'hFF, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03};
        send_frame(0);
        tests_run++;
        if (start_pixel_x !== 7'h7F || start_pixel_y !== 7'h00 || area !== 12'hFFF) begin
            tests_failed++;
            $display("FAIL header_a: x=%02h y=%02h area=%03h, required 7f 00 fff",
                     start_pixel_x, start_pixel_y, area);
        end
        drain(-1, 0, 1'b1);
        frame_q = '{8'h11, 8'h22, 8'h03, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02};
        send_frame(2);
        tests_run++;
        if (start_pixel_x !== 7'h11 || start_pixel_y !== 7'h22 || perimeter !== 8'd3
            || area !== 12'h100 || start !== 1'b1) begin
            tests_failed++;
            $display("FAIL header_b: x=%02h y=%02h p=%0d area=%03h start=%b, required 11 22 3 100 1",
                     start_pixel_x, start_pixel_y, perimeter, area, start);
        end
        drain(-1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_zero_perimeter();
        test_code_error();
        test_header_error();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
